// File: rtl/mem_burst_master_if.sv
// Request, write-stream, read-stream and word-memory command signals of the burst master.
// The master modport is the burst master's view; slave is the requester/memory side.
interface mem_burst_master_if #(
   parameter int LEN_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [15:0]      req_addr;
   logic [LEN_W-1:0] req_len;
   logic             wr_valid;
   logic             wr_ready;
   logic [15:0]      wr_data;
   logic             rsp_valid;
   logic [15:0]      rsp_data;
   logic             rsp_last;
   logic             done;
   logic [1:0]       mem_mode;
   logic [15:0]      mem_addr;
   logic [15:0]      mem_data_in;
   logic [15:0]      mem_data_out;

   modport master (
      input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_data_out,
      output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done,
             mem_mode, mem_addr, mem_data_in
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_data_out,
      input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done,
             mem_mode, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_burst_master.sv
// Burst load/store initiator for the word-memory port: one memory command per cycle,
// with a two-stage valid/last pipe covering the memory's registered read latency.
module mem_burst_master #(
   parameter int         LEN_W     = 4,
   parameter logic [1:0] MODE_IDLE = 2'b00,
   parameter logic [1:0] MODE_IN   = 2'b01,
   parameter logic [1:0] MODE_OUT  = 2'b10
) (
   input logic               clk,
   input logic               reset,
   mem_burst_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_t;

   state_t           state, nxt;
   logic [15:0]      counter;
   logic [LEN_W-1:0] beats_left;
   logic [2:1]       vld_pipe, last_pipe;
   logic [15:0]      rsp_q;
   logic             wr_done;
   logic             issue, wbeat, accept, last_beat;

   assign last_beat = (beats_left == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (bus.req_valid) nxt = bus.req_write ? WR : RD;
         WR:       if (bus.wr_valid && last_beat) nxt = IDLE;
         RD:       if (last_beat) nxt = RD_DRAIN;
         // Once stage 1 is empty the final beat is on the output this cycle.
         RD_DRAIN: if (!vld_pipe[1]) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_comb begin
      accept          = (state == IDLE) && bus.req_valid;
      wbeat           = (state == WR) && bus.wr_valid;
      issue           = (state == RD);
      bus.req_ready   = (state == IDLE);
      bus.wr_ready    = (state == WR);
      bus.mem_mode    = MODE_IDLE;
      bus.mem_addr    = '0;
      bus.mem_data_in = '0;
      if (wbeat) begin
         bus.mem_mode    = MODE_IN;
         bus.mem_data_in = bus.wr_data;
      end else if (issue) begin
         bus.mem_mode = MODE_OUT;
      end
      if (state == WR || state == RD) bus.mem_addr = counter;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         counter    <= '0;
         beats_left <= '0;
         vld_pipe   <= '0;
         last_pipe  <= '0;
         rsp_q      <= '0;
         wr_done    <= 1'b0;
      end else begin
         if (accept) begin
            counter    <= bus.req_addr;
            beats_left <= bus.req_len;
         end else if (wbeat || issue) begin
            counter    <= counter + 16'd1;
            beats_left <= beats_left - LEN_W'(1);
         end
         vld_pipe[1]  <= issue;
         vld_pipe[2]  <= vld_pipe[1];
         last_pipe[1] <= issue && last_beat;
         last_pipe[2] <= last_pipe[1];
         // Memory output is valid the cycle after the issue.
         if (vld_pipe[1]) rsp_q <= bus.mem_data_out;
         wr_done <= wbeat && last_beat;
      end
   end

   assign bus.rsp_valid = vld_pipe[2];
   assign bus.rsp_data  = rsp_q;
   assign bus.rsp_last  = vld_pipe[2] && last_pipe[2];
   assign bus.done      = wr_done || (vld_pipe[2] && last_pipe[2]);
endmodule
